dmem_access_ctrl: RTL and testbench

- Sequencer between the core's load/store unit and the single-port data memory (byte/half/word access selected by funct3, combinational read, synchronous write).
- Accepts one load/store request per valid/ready handshake and drives the memory port.
- Splits misaligned halfword/word accesses into byte-serial accesses and reassembles load data.
- Returns one response per request, carrying load data or an error flag.

---
 rtl/dmem_access_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer in front of a single-port data memory.
// Misaligned half/word accesses are issued as byte-serial sb/lbu cycles and reassembled.
//
// state  | meaning
// IDLE   | ready for a request; request is latched and classified here
// ACCESS | driving the memory port (1 cycle aligned, 2/4 cycles split)
// RESP   | response held until resp_ready
module dmem_access_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter bit SPLIT_EN   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_wr_en,
   output logic [2:0]            mem_funct3,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [2:0]            f3_q, f3_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  split_q, split_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] asm_q, asm_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic                  legal, misal, last;
   logic [DATA_WIDTH-1:0] asm_nxt, asm_ext, wdata_sh;

   always_comb begin
      if (req_we) legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
      else        legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010)
                       || (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
      misal = ((req_funct3[1:0] == 2'b01) && req_addr[0])
           || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   end

   // Split word ends at byte 3, split half at byte 1
   assign last     = (cnt_q == (f3_q[1] ? 2'd3 : 2'd1));
   assign wdata_sh = wdata_q >> {cnt_q, 3'b000};

   always_comb begin
      asm_nxt                         = asm_q;
      asm_nxt[{cnt_q, 3'b000} +: 8]   = mem_rdata[7:0];
      case (f3_q)
         3'b001:  asm_ext = {{16{asm_nxt[15]}}, asm_nxt[15:0]};
         3'b101:  asm_ext = {16'h0000, asm_nxt[15:0]};
         default: asm_ext = asm_nxt;
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      split_d = split_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               split_d = misal && SPLIT_EN;
               cnt_d   = 2'd0;
               asm_d   = '0;
               rdata_d = '0;
               if (!legal || (misal && !SPLIT_EN)) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (!split_q) begin
               if (!we_q) rdata_d = mem_rdata;
               state_d = RESP;
            end else begin
               if (!we_q) asm_d = asm_nxt;
               if (last) begin
                  if (!we_q) rdata_d = asm_ext;
                  state_d = RESP;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end
         RESP: begin
            if (resp_ready) begin
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b010;
         addr_q  <= '0;
         wdata_q <= '0;
         split_q <= 1'b0;
         cnt_q   <= 2'd0;
         asm_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         split_q <= split_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Outputs are forced to their idle values while rst is high so a reset
   // cuts a split store off in the very cycle it is asserted.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      mem_wr_en  = 1'b0;
      mem_funct3 = 3'b010;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (!rst) begin
         req_ready  = (state_q == IDLE);
         resp_valid = (state_q == RESP);
         resp_rdata = rdata_q;
         resp_err   = err_q;
         if (state_q == ACCESS) begin
            mem_wr_en = we_q;
            if (split_q) begin
               mem_funct3 = we_q ? 3'b000 : 3'b100;
               mem_addr   = addr_q + ADDR_WIDTH'(cnt_q);
               mem_wdata  = {{(DATA_WIDTH-8){1'b0}}, wdata_sh[7:0]};
            end else begin
               mem_funct3 = f3_q;
               mem_addr   = addr_q;
               mem_wdata  = wdata_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-array memory model plus a reference model
// that predicts response data, latency and the memory writes of each request.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_valid2 = 1'b0;
   logic        req_ready, req_ready2;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b010;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        resp_valid, resp_valid2;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata, resp_rdata2;
   logic        resp_err, resp_err2;
   logic        mem_wr_en, mem_wr_en2;
   logic [2:0]  mem_funct3, mem_funct3_2;
   logic [31:0] mem_addr, mem_addr2, mem_wdata, mem_wdata2;
   logic [31:0] mem_rdata;
   logic [31:0] mem_rdata2 = '0;

   int n_chk = 0;
   int n_err = 0;
   int wr2_cnt = 0;

   logic [7:0] mem [64];
   logic [7:0] ref_mem [64];

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;
   wr_t wq[$];

   always #5 clk = ~clk;

   dmem_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SPLIT_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   dmem_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SPLIT_EN(1'b0)) u_dut_nosplit (
      .clk(clk), .rst(rst),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid2), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata2), .resp_err(resp_err2),
      .mem_wr_en(mem_wr_en2), .mem_funct3(mem_funct3_2), .mem_addr(mem_addr2),
      .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
   );

   // Memory: combinational read with extension, synchronous write by access size
   always_comb begin
      logic [7:0] b0, b1, b2, b3;
      b0 = mem[mem_addr[5:0]];
      b1 = mem[mem_addr[5:0] + 6'd1];
      b2 = mem[mem_addr[5:0] + 6'd2];
      b3 = mem[mem_addr[5:0] + 6'd3];
      case (mem_funct3)
         3'b000:  mem_rdata = {{24{b0[7]}}, b0};
         3'b100:  mem_rdata = {24'h0, b0};
         3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
         3'b101:  mem_rdata = {16'h0, b1, b0};
         default: mem_rdata = {b3, b2, b1, b0};
      endcase
   end

   always @(posedge clk) begin
      if (mem_wr_en) begin
         wq.push_back('{f: mem_funct3, a: mem_addr, d: mem_wdata});
         mem[mem_addr[5:0]] = mem_wdata[7:0];
         if (mem_funct3[1:0] != 2'b00) mem[mem_addr[5:0] + 6'd1] = mem_wdata[15:8];
         if (mem_funct3[1:0] == 2'b10) begin
            mem[mem_addr[5:0] + 6'd2] = mem_wdata[23:16];
            mem[mem_addr[5:0] + 6'd3] = mem_wdata[31:24];
         end
      end
      if (mem_wr_en2) wr2_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: size/alignment arithmetic over a byte array
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output bit err, output logic [31:0] rd,
                        output int lat, output int size);
      bit legal, mis;
      logic [31:0] v;
      size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      mis   = (a % size) != 0;
      rd    = '0;
      err   = 1'b0;
      if (!legal) begin
         err = 1'b1; lat = 1;
      end else begin
         lat = mis ? size + 1 : 2;
         v = '0;
         for (int k = 0; k < size; k++) begin
            logic [31:0] ak;
            ak = a + 32'(k);
            if (we) ref_mem[ak[5:0]] = wd[8*k +: 8];
            else    v[8*k +: 8] = ref_mem[ak[5:0]];
         end
         if (!we) begin
            if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
            rd = v;
         end
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int hold, output logic [31:0] rd);
      bit e;
      logic [31:0] erd;
      int lat, size, cyc, guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr = $urandom; req_wdata = $urandom;
      req_we = 1'($urandom); req_funct3 = 3'($urandom);
      model(we, f3, a, wd, e, erd, lat, size);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (!resp_valid) chk("req_ready_busy", 32'(req_ready), 32'd0);
      end while (!resp_valid && cyc < 12);
      rd = resp_rdata;
      chk("latency", 32'(cyc), 32'(lat));
      chk("resp_err", 32'(resp_err), 32'(e));
      chk("resp_rdata", resp_rdata, erd);
      // Offer another request during backpressure; it must be ignored
      if (hold > 0) req_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", 32'(resp_valid), 32'd1);
         chk("hold_rdata", resp_rdata, erd);
         chk("hold_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      chk("post_valid", 32'(resp_valid), 32'd0);
      chk("post_ready", 32'(req_ready), 32'd1);
      chk("post_rdata", resp_rdata, 32'd0);
      if (we && !e) begin
         if (lat == 2) begin
            chk("wr_cnt", 32'(wq.size()), 32'd1);
            if (wq.size() > 0) begin
               chk("wr_f3", 32'(wq[0].f), 32'(f3));
               chk("wr_addr", wq[0].a, a);
               chk("wr_data", wq[0].d, wd);
            end
         end else begin
            chk("wr_cnt", 32'(wq.size()), 32'(size));
            for (int k = 0; k < size && k < wq.size(); k++) begin
               chk("sb_f3", 32'(wq[k].f), 32'd0);
               chk("sb_addr", wq[k].a, a + 32'(k));
               chk("sb_data", wq[k].d, {24'h0, wd[8*k +: 8]});
            end
         end
      end else begin
         chk("wr_cnt", 32'(wq.size()), 32'd0);
      end
      wq.delete();
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0] old2, old3;
      logic [2:0] f3;
      logic [31:0] a;

      for (int i = 0; i < 64; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end

      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst_funct3", 32'(mem_funct3), 32'd2);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      chk("idle_mem_addr", mem_addr, 32'd0);
      chk("idle_mem_wdata", mem_wdata, 32'd0);
      chk("idle_resp_rdata", resp_rdata, 32'd0);
      chk("idle_resp_err", 32'(resp_err), 32'd0);

      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd);
      chk("lw_aligned", rd, 32'hDEADBEEF);
      do_req(1'b1, 3'b010, 32'h01, 32'hAABBCCDD, 0, rd);
      do_req(1'b0, 3'b010, 32'h00, 32'h0, 0, rd);
      chk("lw0_upper", {8'h0, rd[31:8]}, 32'h00BBCCDD);
      do_req(1'b0, 3'b010, 32'h04, 32'h0, 0, rd);
      chk("lw4_low", {24'h0, rd[7:0]}, 32'h000000AA);

      mem[3] = 8'h80; ref_mem[3] = 8'h80;
      mem[4] = 8'hFF; ref_mem[4] = 8'hFF;
      do_req(1'b0, 3'b001, 32'h03, 32'h0, 0, rd);
      chk("lh_split", rd, 32'hFFFFFF80);
      do_req(1'b0, 3'b101, 32'h03, 32'h0, 0, rd);
      chk("lhu_split", rd, 32'h0000FF80);

      do_req(1'b0, 3'b011, 32'h08, 32'h0, 0, rd);
      do_req(1'b1, 3'b100, 32'h08, 32'h12345678, 0, rd);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, rd);

      // Misaligned word on the non-splitting instance
      @(negedge clk);
      chk("ns_ready", 32'(req_ready2), 32'd1);
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h02; req_valid2 = 1'b1;
      @(posedge clk);
      #1 req_valid2 = 1'b0;
      @(negedge clk);
      chk("ns_valid", 32'(resp_valid2), 32'd1);
      chk("ns_err", 32'(resp_err2), 32'd1);
      chk("ns_rdata", resp_rdata2, 32'd0);
      chk("ns_mem_addr", mem_addr2, 32'd0);
      chk("ns_mem_f3", 32'(mem_funct3_2), 32'd2);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      chk("ns_released", 32'(resp_valid2), 32'd0);

      // Reset while the third byte of a split sw is on the port
      old2 = mem[6'h23];
      old3 = mem[6'h24];
      wq.delete();
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h21; req_wdata = 32'h44332211;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rstmid_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rstmid_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rstmid_ready_after", 32'(req_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("rstmid_no_resp", 32'(resp_valid), 32'd0);
         @(negedge clk);
      end
      chk("rstmid_b0", 32'(mem[6'h21]), 32'h11);
      chk("rstmid_b1", 32'(mem[6'h22]), 32'h22);
      chk("rstmid_b2", 32'(mem[6'h23]), 32'(old2));
      chk("rstmid_b3", 32'(mem[6'h24]), 32'(old3));
      chk("rstmid_wr_cnt", 32'(wq.size()), 32'd2);
      wq.delete();
      ref_mem[6'h21] = 8'h11;
      ref_mem[6'h22] = 8'h22;

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 9) < 8) begin
            case ($urandom_range(0, 4))
               0: f3 = 3'b000;
               1: f3 = 3'b001;
               2: f3 = 3'b010;
               3: f3 = 3'b100;
               default: f3 = 3'b101;
            endcase
         end else begin
            f3 = 3'($urandom);
         end
         if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         else                           a = 32'($urandom_range(0, 63));
         do_req(1'($urandom), f3, a, $urandom, $urandom_range(0, 2), rd);
      end

      for (int i = 0; i < 64; i++) chk("mem_final", 32'(mem[i]), 32'(ref_mem[i]));
      chk("ns_no_writes", 32'(wr2_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
